// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-low patterns, seg[0]=a .. seg[6]=g.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    localparam logic [SEG_W-1:0] SEG_0    = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1    = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2    = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3    = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4    = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5    = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6    = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7    = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8    = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9    = 7'h10;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD code to active-low segment pattern; codes 10..15 show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] code,
    output logic [SEG_W-1:0] pattern_c
);

    always_comb begin
        pattern_c = SEG_DASH;
        case (code)
            4'd0:    pattern_c = SEG_0;
            4'd1:    pattern_c = SEG_1;
            4'd2:    pattern_c = SEG_2;
            4'd3:    pattern_c = SEG_3;
            4'd4:    pattern_c = SEG_4;
            4'd5:    pattern_c = SEG_5;
            4'd6:    pattern_c = SEG_6;
            4'd7:    pattern_c = SEG_7;
            4'd8:    pattern_c = SEG_8;
            4'd9:    pattern_c = SEG_9;
            default: pattern_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode 7-segment scanner with per-frame digit snapshot.
// Optional BLANK_LEAD_ZERO_EN: suppress leading zero digits (digit 0 always shown).
module seg_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NDIGITS   = 8,
    parameter int unsigned PRESCALE  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [4*NDIGITS-1:0]         digits,
    output logic [6:0]                   seg,
    output logic [NDIGITS-1:0]           an,
    output logic [$clog2(NDIGITS)-1:0]   scan_idx,
    output logic                         frame_done
);

    localparam int unsigned IDX_W = $clog2(NDIGITS);
    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned DIG_W = BCD_W * NDIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIGITS - 1);

    logic [CNT_W-1:0]   pre_cnt;
    logic [DIG_W-1:0]   snapshot;
    logic               primed;
    logic               slot_end;
    logic               frame_wrap;
    logic               load_snap;
    logic               in_blank;
    logic               digit_blank;
    logic [BCD_W-1:0]   cur_digit;
    logic [SEG_W-1:0]   dec_seg;
    logic [NDIGITS-1:0] an_sel;

    assign slot_end   = enable && (pre_cnt == CNT_LAST);
    assign frame_wrap = slot_end && (scan_idx == IDX_LAST);
    assign load_snap  = enable && (frame_wrap || !primed);
    assign in_blank   = (pre_cnt < BLANK_END);

    // Prescaler, scan index and frame pulse; all frozen while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt    <= '0;
            scan_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (enable) begin
                if (slot_end) begin
                    pre_cnt  <= '0;
                    scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
                end else begin
                    pre_cnt <= pre_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Whole-bus snapshot at frame start keeps a frame free of counter-carry tearing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snapshot <= '0;
            primed   <= 1'b0;
        end else begin
            if (load_snap) begin
                snapshot <= digits;
            end
            if (enable) begin
                primed <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        an_sel    = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_digit = snapshot[BCD_W*i +: BCD_W];
                an_sel[i] = 1'b0;
            end
        end
    end

`ifdef BLANK_LEAD_ZERO_EN
    // zero_above[i] is set when snapshot digits i..NDIGITS-1 are all zero.
    logic [NDIGITS:0] zero_above;

    always_comb begin
        zero_above          = '0;
        zero_above[NDIGITS] = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (snapshot[BCD_W*i +: BCD_W] == 4'd0);
        end
        digit_blank = 1'b0;
        for (int i = 1; i < NDIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                digit_blank = zero_above[i];
            end
        end
    end
`else
    assign digit_blank = 1'b0;
`endif

    seg7_decode u_decode (
        .code      (cur_digit),
        .pattern_c (dec_seg)
    );

    // Display pins lag the scan state by one cycle; slot start is blanked against ghosting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg <= SEG_OFF;
            an  <= '1;
        end else if (!enable || in_blank) begin
            seg <= SEG_OFF;
            an  <= '1;
        end else begin
            seg <= digit_blank ? SEG_OFF : dec_seg;
            an  <= an_sel;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: time-based reference model feeds an expected-output queue.
module tb_seg_scan_mux;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int BLANK = 1;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] digits;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  scan_idx;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];

    int m_ticks;
    int snap [N];
    bit m_started;

    seg_scan_mux #(
        .NDIGITS   (N),
        .PRESCALE  (P),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .digits     (digits),
        .seg        (seg),
        .an         (an),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic bit zeros_from(input int s);
        for (int j = s; j < N; j++) begin
            if (snap[j] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: position in the scan is purely a function of enabled cycles since reset.
    always @(posedge clk) begin
        exp_t e;
        int   slot;
        int   phase;
        if (!reset_n) begin
            m_ticks   = 0;
            m_started = 1'b0;
            for (int i = 0; i < N; i++) snap[i] = 0;
            e = '{seg: 7'h7F, an: 4'hF, idx: 2'd0, fd: 1'b0};
        end else if (enable) begin
            slot  = (m_ticks / P) % N;
            phase = m_ticks % P;
            e.seg = 7'h7F;
            e.an  = 4'hF;
            if (phase >= BLANK) begin
                e.an  = 4'hF & ~(4'b0001 << slot);
                e.seg = ref_seg(snap[slot]);
`ifdef BLANK_LEAD_ZERO_EN
                if (slot > 0 && zeros_from(slot)) e.seg = 7'h7F;
`endif
            end
            m_ticks++;
            e.idx = 2'((m_ticks / P) % N);
            e.fd  = ((m_ticks % (P * N)) == 0);
            if (!m_started || e.fd) begin
                for (int i = 0; i < N; i++) snap[i] = int'(digits[4*i +: 4]);
            end
            m_started = 1'b1;
        end else begin
            e = '{seg: 7'h7F, an: 4'hF, idx: 2'((m_ticks / P) % N), fd: 1'b0};
        end
        q.push_back(e);
    end

    // Monitor: every cycle the DUT presents a new registered output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                check("seg", 32'(seg), 32'(e.seg));
                check("an", 32'(an), 32'(e.an));
                check("scan_idx", 32'(scan_idx), 32'(e.idx));
                check("frame_done", 32'(frame_done), 32'(e.fd));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_slot(input int s, input int ph);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (((m_ticks / P) % N) == s && (m_ticks % P) == ph) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) check("wait_slot_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        for (int i = 0; i < N; i++) begin
            d[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        return d;
    endfunction

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        digits  = 16'h0000;
        cyc(3);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_idx", 32'(scan_idx), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);

        digits  = 16'h1234;
        enable  = 1'b1;
        reset_n = 1'b1;
        cyc(40);

        wait_slot(2, 1);
        digits = 16'h5678;
        cyc(40);

        digits = 16'h00AF;
        cyc(40);

        wait_slot(1, 2);
        enable = 1'b0;
        cyc(10);
        enable = 1'b1;
        cyc(20);

        // Asynchronous reset between clock edges
        cyc(7);
        #1 reset_n = 1'b0;
        #1;
        check("async_seg", 32'(seg), 32'h7F);
        check("async_an", 32'(an), 32'hF);
        check("async_idx", 32'(scan_idx), 32'd0);
        check("async_fd", 32'(frame_done), 32'd0);
        cyc(2);
        reset_n = 1'b1;
        digits  = 16'h9012;
        cyc(30);

        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) digits = rand_digits();
            cyc(1);
        end
        enable = 1'b1;
        digits = 16'h0007;
        cyc(40);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
